// File: rtl/line_collector.sv
// Captures a packed per-PE result bus on load and streams it out one word per cycle, tap 0 first.
// Optional LINE_COLLECTOR_OVERFLOW_EN adds a sticky overflow flag and a saturating dropped-load count.
module line_collector #(
  parameter int pNoTaps     = 8,
  parameter int pDataLength = 16,
  parameter int pPtrLength  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           load,
  input  logic [pDataLength*pNoTaps-1:0] taps_in,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [pDataLength-1:0]         out_data,
  output logic [pPtrLength-1:0]          out_idx,
  output logic                           out_last
`ifdef LINE_COLLECTOR_OVERFLOW_EN
  ,
  output logic                           overflow,
  output logic [7:0]                     overflow_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [pPtrLength-1:0] LAST_IDX = pPtrLength'(pNoTaps - 1);

  state_t                                   r_state;
  state_t                                   w_state_nxt;
  logic [pNoTaps-1:0][pDataLength-1:0]      r_cap;
  logic [pDataLength-1:0]                   r_data;
  logic [pPtrLength-1:0]                    r_idx;
  logic [pPtrLength-1:0]                    w_idx_inc;
  logic                                     w_hs;
  logic                                     w_fin;
  logic                                     w_load_acc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load_acc) w_state_nxt = SHIFT;
      SHIFT:   if (w_fin && !w_load_acc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / handshake logic; in_ready is combinational from out_ready so a new
  // line can be taken on the same edge the last word leaves.
  always_comb begin
    out_valid  = (r_state == SHIFT);
    out_last   = out_valid && (r_idx == LAST_IDX);
    out_data   = r_data;
    out_idx    = r_idx;
    w_hs       = out_valid && out_ready;
    w_fin      = w_hs && out_last;
    in_ready   = (r_state == IDLE) || w_fin;
    w_load_acc = load && in_ready;
    w_idx_inc  = r_idx + pPtrLength'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap  <= '0;
      r_data <= '0;
      r_idx  <= '0;
    end else if (clear) begin
      r_cap  <= '0;
      r_data <= '0;
      r_idx  <= '0;
    end else if (w_load_acc) begin
      r_cap  <= taps_in;
      r_data <= taps_in[pDataLength-1:0];
      r_idx  <= '0;
    end else if (w_fin) begin
      r_data <= '0;
      r_idx  <= '0;
    end else if (w_hs) begin
      r_data <= r_cap[w_idx_inc];
      r_idx  <= w_idx_inc;
    end
  end

`ifdef LINE_COLLECTOR_OVERFLOW_EN
  logic       w_drop;
  logic       r_ovf;
  logic [7:0] r_ovf_cnt;

  assign w_drop = load && !in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (clear) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign overflow       = r_ovf;
  assign overflow_count = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_line_collector.sv
// Bench for line_collector: directed vector table, corner-case sequences and random traffic against a queue model.
module tb_line_collector;
  localparam int N = 8;
  localparam int W = 16;
  localparam int P = 3;

  logic             clk = 1'b0;
  logic             reset, clear, load, out_ready;
  logic [N*W-1:0]   taps_in;
  logic             in_ready, out_valid, out_last;
  logic [W-1:0]     out_data;
  logic [P-1:0]     out_idx;
`ifdef LINE_COLLECTOR_OVERFLOW_EN
  logic             overflow;
  logic [7:0]       overflow_count;
`endif

  line_collector #(.pNoTaps(N), .pDataLength(W), .pPtrLength(P)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .taps_in(taps_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
`ifdef LINE_COLLECTOR_OVERFLOW_EN
    , .overflow(overflow), .overflow_count(overflow_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] base);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = base + W'(i);
    return r;
  endfunction

  // Reference model: queue of words still owed to the downstream side.
  typedef struct { logic [W-1:0] d; int i; } wd_t;
  wd_t mq[$];
  bit  m_ovf;
  int  m_ocnt;

  function automatic bit m_rdy(input bit ordy);
    return (mq.size() == 0) || (mq.size() == 1 && ordy);
  endfunction

  function automatic void m_flush();
    mq.delete();
    m_ovf  = 1'b0;
    m_ocnt = 0;
  endfunction

  function automatic void mdl_step(input bit ld, input logic [N*W-1:0] taps, input bit ordy, input bit clr);
    bit rdy;
    wd_t w;
    rdy = m_rdy(ordy);
    if (clr) begin
      m_flush();
      return;
    end
    if (ld && !rdy) begin
      m_ovf = 1'b1;
      if (m_ocnt < 255) m_ocnt++;
    end
    if (mq.size() > 0 && ordy) void'(mq.pop_front());
    if (ld && rdy)
      for (int k = 0; k < N; k++) begin
        w.d = taps[k*W +: W];
        w.i = k;
        mq.push_back(w);
      end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_vld"}, out_valid, mq.size() > 0);
    chk({tag, "_in_rdy"}, in_ready, m_rdy(out_ready));
    if (mq.size() > 0) begin
      chk({tag, "_data"}, out_data, mq[0].d);
      chk({tag, "_idx"}, out_idx, mq[0].i);
      chk({tag, "_last"}, out_last, mq[0].i == N-1);
    end else begin
      chk({tag, "_idle_idx"}, out_idx, 0);
      chk({tag, "_idle_last"}, out_last, 0);
    end
`ifdef LINE_COLLECTOR_OVERFLOW_EN
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_ovf_cnt"}, overflow_count, m_ocnt);
`endif
  endtask

  // Drive one cycle, check mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input bit ld, input logic [N*W-1:0] taps, input bit ordy, input bit clr);
    load = ld; taps_in = taps; out_ready = ordy; clear = clr;
    #1;
    check_model(tag);
    @(posedge clk);
    mdl_step(ld, taps, ordy, clr);
    #1;
  endtask

  typedef struct {
    bit ld; logic [W-1:0] base; bit ordy;
    bit ev; logic [W-1:0] ed; int ei; bit el; bit er;
  } vec_t;
  vec_t vecs[$];

  task automatic row(input bit ld, input logic [W-1:0] base, input bit ordy,
                     input bit ev, input logic [W-1:0] ed, input int ei, input bit el, input bit er);
    vec_t v;
    v.ld = ld; v.base = base; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ei = ei; v.el = el; v.er = er;
    vecs.push_back(v);
  endtask

  initial begin
    int ws[11];
    bit rs[11];
    int nv;
    logic [N*W-1:0] rt;

    reset = 1'b1; clear = 1'b0; load = 1'b0; out_ready = 1'b0; taps_in = '0;
    m_flush();

    // Basic line
    row(1, 16'h0100, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < N; k++) row(0, 0, 1, 1, 16'h0100 + W'(k), k, k == N-1, k == N-1);
    row(0, 0, 1, 0, 0, 0, 0, 1);
    // Backpressure on stream cycles 2..4
    ws = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    rs = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    row(1, 16'h0100, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 11; k++)
      row(0, 0, rs[k], 1, 16'h0100 + W'(ws[k]), ws[k], ws[k] == N-1, ws[k] == N-1 && rs[k]);
    row(0, 0, 1, 0, 0, 0, 0, 1);

    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_in_rdy", in_ready, 1);
`ifdef LINE_COLLECTOR_OVERFLOW_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_ovf_cnt", overflow_count, 0);
`endif
    reset = 1'b0;

    foreach (vecs[k]) begin
      load = vecs[k].ld; taps_in = mk(vecs[k].base); out_ready = vecs[k].ordy; clear = 1'b0;
      #1;
      chk($sformatf("tbl%0d_vld", k), out_valid, vecs[k].ev);
      chk($sformatf("tbl%0d_in_rdy", k), in_ready, vecs[k].er);
      chk($sformatf("tbl%0d_last", k), out_last, vecs[k].el);
      chk($sformatf("tbl%0d_idx", k), out_idx, vecs[k].ei);
      if (vecs[k].ev) chk($sformatf("tbl%0d_data", k), out_data, vecs[k].ed);
      @(posedge clk);
      mdl_step(vecs[k].ld, mk(vecs[k].base), vecs[k].ordy, 1'b0);
      #1;
    end

    // Back-to-back lines: second load on the fin cycle of the first
    nv = 0;
    cyc("b2b", 1, mk(16'h0100), 1, 0);
    for (int k = 0; k < N; k++) begin
      nv += int'(out_valid);
      cyc("b2b", k == N-1, mk(16'h0200), 1, 0);
    end
    for (int k = 0; k < N; k++) begin
      nv += int'(out_valid);
      cyc("b2b", 0, '0, 1, 0);
    end
    chk("b2b_valid_count", nv, 16);
    cyc("b2b", 0, '0, 1, 0);

    // Dropped load mid-line at idx 3
    cyc("drop", 1, mk(16'h0100), 1, 0);
    for (int k = 0; k < 3; k++) cyc("drop", 0, '0, 1, 0);
    chk("drop_at_idx3", out_idx, 3);
    cyc("drop", 1, {N{16'hDEAD}}, 1, 0);
`ifdef LINE_COLLECTOR_OVERFLOW_EN
    chk("drop_ovf", overflow, 1);
    chk("drop_ovf_cnt", overflow_count, 1);
`endif
    for (int k = 0; k < 4; k++) cyc("drop", 0, '0, 1, 0);
    cyc("drop_clr", 0, '0, 1, 1);
    cyc("drop_post", 0, '0, 1, 0);

    // Async reset at idx 5
    cyc("arst", 1, mk(16'h0100), 1, 0);
    for (int k = 0; k < 5; k++) cyc("arst", 0, '0, 1, 0);
    chk("arst_at_idx5", out_idx, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);
    m_flush();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    cyc("arst_re", 1, mk(16'h0500), 1, 0);
    for (int k = 0; k < N + 1; k++) cyc("arst_re", 0, '0, 1, 0);

    // Sync clear at idx 5 together with a load
    cyc("clr", 1, mk(16'h0100), 1, 0);
    for (int k = 0; k < 5; k++) cyc("clr", 0, '0, 1, 0);
    cyc("clr_ld", 1, mk(16'h0300), 1, 1);
    cyc("clr_post", 0, '0, 1, 0);
    cyc("clr_re", 1, mk(16'h0400), 1, 0);
    for (int k = 0; k < N + 1; k++) cyc("clr_re", 0, '0, 1, 0);

    // Drop-count saturation
    cyc("sat", 1, mk(16'h0600), 0, 0);
    for (int k = 0; k < 300; k++) cyc("sat", 1, mk(16'h0700), 0, 0);
    for (int k = 0; k < N + 1; k++) cyc("sat", 0, '0, 1, 0);
    cyc("sat_clr", 0, '0, 1, 1);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) rt[k*W +: W] = W'($urandom);
      cyc("rnd", ($urandom % 3) == 0, rt, ($urandom % 4) != 0, ($urandom % 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/line_collector.md
Name: line_collector

Overview:
- Drain-side counterpart of the line buffer: captures the packed per-PE result bus (one word per tap/PE) in parallel on a load strobe.
- Serialises the captured words out one word per cycle, tap 0 first, over a valid/ready stream.
- Sits between the PE array outputs and the downstream accumulation/writeback path.
- Supports back-to-back lines with zero bubble.

Parameters:
- pNoTaps, 8, number of words captured per line (one per PE tap); must be ≥ 2.
- pDataLength, 16, bit width of each word.
- pPtrLength, 3, width of the word index; must satisfy 2^pPtrLength ≥ pNoTaps.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear; same effect as reset, applied at the clock edge.
- load  input  1  capture strobe for taps_in.
- taps_in  input  pDataLength*pNoTaps  packed words; word i = taps_in[pDataLength*(i+1)-1 : pDataLength*i].
- in_ready  output  1  block accepts a load this cycle (combinational).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  pDataLength  current word.
- out_idx  output  pPtrLength  index of current word, 0..pNoTaps-1.
- out_last  output  1  current word is word pNoTaps-1.

Behaviour:
- Reset (async) or clear (sync) state:
  - state = IDLE; out_valid = 0; out_idx = 0; out_last = 0; out_data = 0; capture register = 0.
  - Overflow flag = 0 (when the optional feature is built).
  - clear has priority over load and over the output handshake in the same cycle.
- States: IDLE and SHIFT.
- Handshake definitions:
  - hs = out_valid & out_ready.
  - fin = hs & out_last.
  - in_ready = (state == IDLE) | fin. This is a combinational path from out_ready to in_ready.
  - Load is accepted only when load & in_ready.
- IDLE:
  - in_ready = 1; out_valid = 0.
  - On an accepted load: capture all of taps_in, go to SHIFT, set out_idx = 0.
  - Next cycle: out_valid = 1 and out_data = word 0.
  - Latency from load to first valid word is 1 cycle.
- SHIFT:
  - out_valid = 1. out_data is registered and always equals captured word out_idx.
  - out_last = (out_idx == pNoTaps-1).
  - No hs: all outputs hold stable, with no data change while valid and not ready.
  - hs without last: out_idx increments by 1 and out_data advances to the next word.
  - fin without accepted load: go to IDLE; out_valid = 0 next cycle; out_idx = 0.
  - fin with accepted load in the same cycle: capture the new taps_in, stay in SHIFT, out_idx = 0, out_data = new word 0. No bubble.
- Load rules:
  - A load while in_ready = 0 is ignored; captured data and stream state are unchanged.
  - taps_in is sampled only on an accepted load.
- Throughput: pNoTaps cycles per line minimum, sustained, when out_ready is held at 1.
- Reset asserted mid-line: the line is discarded and outputs drop immediately (asynchronously) to reset values.
- No arithmetic; the index never wraps past pNoTaps-1.

Optional Feature:
- Macro: LINE_COLLECTOR_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit): a sticky flag set on the clock edge after any cycle with load & ~in_ready.
  - Cleared only by reset or clear.
  - Also adds output port overflow_count (8 bits): saturating count of dropped loads, 0 after reset or clear, holds at 255.
- Undefined: neither port exists. Dropped loads are silently ignored; all other behaviour is identical.

Test Plan:
1. Basic line:
   - Stimulus: reset, then load with pNoTaps=8, word i = 16'h0100+i; out_ready held 1.
   - Required: out_valid rises 1 cycle after load; out_data 0100..0107 on 8 consecutive cycles; out_idx 0..7; out_last only with 0107; out_valid 0 on the 9th cycle.
2. Backpressure:
   - Stimulus: same line; out_ready = 0 during cycles 2–4 of the stream.
   - Required: out_data/out_idx hold at 0102/2 through the stall; every word appears exactly once, in order.
3. Back-to-back lines:
   - Stimulus: a second load (words 16'h0200+i) asserted in the same cycle as the fin of the first line.
   - Required: in_ready = 1 that cycle; the next cycle shows 0200 with out_idx 0 and no invalid gap; 16 valid words over 16 consecutive cycles.
4. Dropped load:
   - Stimulus: load of 16'hDEAD words while mid-line at out_idx 3.
   - Required: stream continues 0104..0107 unchanged.
   - With LINE_COLLECTOR_OVERFLOW_EN: overflow = 1 and overflow_count = 1 next cycle, then clear returns both to 0.
5. Reset/clear mid-line:
   - Stimulus: assert reset asynchronously at out_idx 5; in a separate run, assert clear at out_idx 5 together with load.
   - Required: reset drops out_valid immediately; clear drops out_valid at the next edge and the load is ignored; the subsequent load restarts cleanly at word 0.
